dram_rrarb: RTL and testbench

//  N-channel DRAM access arbiter, parametrised successor of the fixed CPU/video arbiter.
//  - Sits between up to NCH memory clients (CPU, video fetch, DMA, ...) and the dram controller.
//  - One request is granted per DRAM cycle: optional fixed-priority channel, round-robin

---
 rtl/dram_rrarb.sv | 136 +++++++++++++
 tb/tb_dram_rrarb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_rrarb.sv
// N-channel DRAM access arbiter: starvation override, optional fixed-priority channel,
// round-robin among the rest, and routing of returned read data to the owning channel.
module dram_rrarb #(
    parameter int NCH     = 4,
    parameter int AW      = 21,
    parameter int DW      = 16,
    parameter int PRIO_CH = 0,
    parameter int PRIO_EN = 1,
    parameter int MAXWAIT = 3
) (
    input  logic              fclk,
    input  logic              rst_n,
    input  logic              cbeg,
    input  logic              dram_rrdy,
    input  logic [DW-1:0]     dram_rddata,
    output logic              dram_req,
    output logic              dram_rnw,
    output logic [AW-1:0]     dram_addr,
    output logic [DW-1:0]     dram_wrdata,
    output logic [1:0]        dram_bsel,
    input  logic [NCH-1:0]    ch_req,
    input  logic [NCH-1:0]    ch_rnw,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*DW-1:0] ch_wrdata,
    input  logic [NCH*2-1:0]  ch_bsel,
    output logic [NCH-1:0]    ch_grant,
    output logic [NCH-1:0]    ch_rdstb,
    output logic [DW-1:0]     ch_rddata
);

    localparam int IW = $clog2(NCH);

    logic [IW-1:0]  rr_last;
    logic [IW-1:0]  iss_owner;
    logic [IW-1:0]  ex_owner;
    logic           ex_valid;
    logic           ex_rnw;
    logic [3:0]     wait_cnt [NCH];

    logic [NCH-1:0] starve;
    logic [IW-1:0]  win;
    logic           win_valid;
    logic           win_rr;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int unsigned k);
        return IW'((32'(base) + k) % NCH);
    endfunction

    always_comb begin
        starve    = '0;
        win       = '0;
        win_valid = 1'b0;
        win_rr    = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            starve[i] = ch_req[i] && (wait_cnt[i] >= 4'(MAXWAIT));
        end
        // Starvation override, scanned in round-robin order from rr_last+1
        for (int unsigned k = 1; k <= NCH; k++) begin
            if (!win_valid && starve[rr_idx(rr_last, k)]) begin
                win_valid = 1'b1;
                win_rr    = 1'b1;
                win       = rr_idx(rr_last, k);
            end
        end
        if (!win_valid && (PRIO_EN != 0) && ch_req[PRIO_CH]) begin
            win_valid = 1'b1;
            win       = IW'(PRIO_CH);
        end
        for (int unsigned k = 1; k <= NCH; k++) begin
            if (!win_valid && ch_req[rr_idx(rr_last, k)]) begin
                win_valid = 1'b1;
                win_rr    = 1'b1;
                win       = rr_idx(rr_last, k);
            end
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            dram_req    <= 1'b0;
            dram_rnw    <= 1'b0;
            dram_addr   <= '0;
            dram_wrdata <= '0;
            dram_bsel   <= '0;
            ch_grant    <= '0;
            ch_rdstb    <= '0;
            ch_rddata   <= '0;
            rr_last     <= IW'(NCH - 1);
            iss_owner   <= '0;
            ex_owner    <= '0;
            ex_valid    <= 1'b0;
            ex_rnw      <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            ch_grant <= '0;
            // Return uses the exec slot as it was before any shift on this edge
            if (dram_rrdy && ex_valid && ex_rnw) begin
                ch_rddata <= dram_rddata;
                ch_rdstb  <= NCH'(1) << ex_owner;
            end else begin
                ch_rdstb  <= '0;
            end
            if (cbeg) begin
                dram_req <= win_valid;
                if (win_valid) begin
                    dram_rnw    <= ch_rnw[win];
                    dram_addr   <= ch_addr[win*AW +: AW];
                    dram_wrdata <= ch_wrdata[win*DW +: DW];
                    dram_bsel   <= ch_bsel[win*2 +: 2];
                    iss_owner   <= win;
                    ch_grant    <= NCH'(1) << win;
                end
                if (win_rr) begin
                    rr_last <= win;
                end
                ex_valid <= dram_req;
                ex_rnw   <= dram_rnw;
                ex_owner <= iss_owner;
            end
            for (int unsigned i = 0; i < NCH; i++) begin
                if (!ch_req[i]) begin
                    wait_cnt[i] <= '0;
                end else if (cbeg) begin
                    if (win_valid && (win == IW'(i))) begin
                        wait_cnt[i] <= '0;
                    end else if (wait_cnt[i] != 4'hF) begin
                        wait_cnt[i] <= wait_cnt[i] + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_rrarb.sv
// Directed bench for dram_rrarb: a priority-enabled instance and a pure round-robin
// instance share all inputs; expected values are hand-computed per step.
module tb_dram_rrarb;

    localparam int NCH = 4;
    localparam int AW  = 21;
    localparam int DW  = 16;

    logic              fclk = 1'b0;
    logic              rst_n = 1'b1;
    logic              cbeg = 1'b0;
    logic              dram_rrdy = 1'b0;
    logic [DW-1:0]     dram_rddata = '0;
    logic [NCH-1:0]    ch_req = '0;
    logic [NCH-1:0]    ch_rnw = '0;
    logic [NCH*AW-1:0] ch_addr = '0;
    logic [NCH*DW-1:0] ch_wrdata = '0;
    logic [NCH*2-1:0]  ch_bsel = '0;

    logic              pr_dram_req, pr_dram_rnw;
    logic [AW-1:0]     pr_dram_addr;
    logic [DW-1:0]     pr_dram_wrdata;
    logic [1:0]        pr_dram_bsel;
    logic [NCH-1:0]    pr_grant, pr_rdstb;
    logic [DW-1:0]     pr_rddata;

    logic              rr_dram_req, rr_dram_rnw;
    logic [AW-1:0]     rr_dram_addr;
    logic [DW-1:0]     rr_dram_wrdata;
    logic [1:0]        rr_dram_bsel;
    logic [NCH-1:0]    rr_grant, rr_rdstb;
    logic [DW-1:0]     rr_rddata;

    int total = 0;
    int bad   = 0;
    int strb_cnt [NCH] = '{default: 0};
    int strb_sum = 0;
    int gnt_sum  = 0;
    int snap1, snap2, snap3, snap_sum, snap_gnt;

    dram_rrarb #(.NCH(NCH), .AW(AW), .DW(DW), .PRIO_CH(0), .PRIO_EN(1), .MAXWAIT(3)) u_pr (
        .fclk(fclk), .rst_n(rst_n), .cbeg(cbeg), .dram_rrdy(dram_rrdy), .dram_rddata(dram_rddata),
        .dram_req(pr_dram_req), .dram_rnw(pr_dram_rnw), .dram_addr(pr_dram_addr),
        .dram_wrdata(pr_dram_wrdata), .dram_bsel(pr_dram_bsel),
        .ch_req(ch_req), .ch_rnw(ch_rnw), .ch_addr(ch_addr), .ch_wrdata(ch_wrdata), .ch_bsel(ch_bsel),
        .ch_grant(pr_grant), .ch_rdstb(pr_rdstb), .ch_rddata(pr_rddata)
    );

    dram_rrarb #(.NCH(NCH), .AW(AW), .DW(DW), .PRIO_CH(0), .PRIO_EN(0), .MAXWAIT(3)) u_rr (
        .fclk(fclk), .rst_n(rst_n), .cbeg(cbeg), .dram_rrdy(dram_rrdy), .dram_rddata(dram_rddata),
        .dram_req(rr_dram_req), .dram_rnw(rr_dram_rnw), .dram_addr(rr_dram_addr),
        .dram_wrdata(rr_dram_wrdata), .dram_bsel(rr_dram_bsel),
        .ch_req(ch_req), .ch_rnw(ch_rnw), .ch_addr(ch_addr), .ch_wrdata(ch_wrdata), .ch_bsel(ch_bsel),
        .ch_grant(rr_grant), .ch_rdstb(rr_rdstb), .ch_rddata(rr_rddata)
    );

    always #5 fclk = ~fclk;

    // Pulses last one full fclk period, so each is seen at exactly one falling edge
    always @(negedge fclk) begin
        for (int i = 0; i < NCH; i++) begin
            if (pr_rdstb[i]) begin
                strb_cnt[i] = strb_cnt[i] + 1;
                strb_sum    = strb_sum + 1;
            end
            if (pr_grant[i]) gnt_sum = gnt_sum + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic c, input logic r, input logic [DW-1:0] d);
        cbeg        = c;
        dram_rrdy   = r;
        dram_rddata = d;
        @(posedge fclk);
        #1;
        cbeg      = 1'b0;
        dram_rrdy = 1'b0;
    endtask

    task automatic do_reset();
        ch_req    = '0;
        cbeg      = 1'b0;
        dram_rrdy = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge fclk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        ch_addr[0*AW +: AW] = 21'h00100;
        ch_addr[1*AW +: AW] = 21'h00101;
        ch_addr[2*AW +: AW] = 21'h00102;
        ch_addr[3*AW +: AW] = 21'h00103;
        #1;
        do_reset();
        chk("rst_dram_req", 32'(pr_dram_req), 32'd0);
        chk("rst_dram_addr", 32'(pr_dram_addr), 32'd0);
        chk("rst_grant", 32'({pr_grant, rr_grant}), 32'd0);
        chk("rst_rdstb_rddata", 32'({pr_rdstb, pr_rddata}), 32'd0);

        // 1: pure round-robin, all four requesting
        ch_req = 4'b1111;
        ch_rnw = 4'b1111;
        tick(1, 0, '0);
        chk("rr_grant0", 32'(rr_grant), 32'h1);
        chk("rr_addr0", 32'(rr_dram_addr), 32'h100);
        chk("rr_req0", 32'(rr_dram_req), 32'd1);
        tick(0, 0, '0);
        chk("rr_grant_pulse", 32'(rr_grant), 32'h0);
        chk("rr_addr_stable", 32'(rr_dram_addr), 32'h100);
        tick(0, 0, '0); tick(0, 0, '0);
        tick(1, 0, '0);
        chk("rr_grant1", 32'(rr_grant), 32'h2);
        chk("rr_addr1", 32'(rr_dram_addr), 32'h101);
        tick(0, 0, '0); tick(0, 0, '0); tick(0, 0, '0);
        tick(1, 0, '0);
        chk("rr_grant2", 32'(rr_grant), 32'h4);
        chk("rr_addr2", 32'(rr_dram_addr), 32'h102);
        tick(0, 0, '0); tick(0, 0, '0); tick(0, 0, '0);
        tick(1, 0, '0);
        chk("rr_grant3", 32'(rr_grant), 32'h8);
        chk("rr_addr3", 32'(rr_dram_addr), 32'h103);
        tick(0, 0, '0); tick(0, 0, '0); tick(0, 0, '0);
        tick(1, 0, '0);
        chk("rr_grant_wrap", 32'(rr_grant), 32'h1);
        chk("rr_addr_wrap", 32'(rr_dram_addr), 32'h100);

        // 2: priority channel 0 vs ch2 with starvation override after 3 losses
        do_reset();
        ch_req = 4'b0101;
        tick(1, 0, '0);
        chk("prio_win1", 32'(pr_grant), 32'h1);
        tick(0, 0, '0); tick(0, 0, '0);
        tick(1, 0, '0);
        chk("prio_win2", 32'(pr_grant), 32'h1);
        tick(0, 0, '0); tick(0, 0, '0);
        tick(1, 0, '0);
        chk("prio_win3", 32'(pr_grant), 32'h1);
        tick(0, 0, '0); tick(0, 0, '0);
        tick(1, 0, '0);
        chk("starve_forced", 32'(pr_grant), 32'h4);
        chk("starve_addr", 32'(pr_dram_addr), 32'h102);
        tick(0, 0, '0); tick(0, 0, '0);
        tick(1, 0, '0);
        chk("prio_resume", 32'(pr_grant), 32'h1);

        // 3: single read by ch1
        do_reset();
        ch_addr[1*AW +: AW] = 21'h1ABCD;
        ch_rnw = 4'b0010;
        ch_req = 4'b0010;
        snap1 = strb_cnt[1];
        snap_sum = strb_sum;
        tick(1, 0, '0);
        chk("rd_grant", 32'(pr_grant), 32'h2);
        chk("rd_addr", 32'(pr_dram_addr), 32'h1ABCD);
        chk("rd_rnw", 32'(pr_dram_rnw), 32'd1);
        ch_req = '0;
        tick(0, 0, '0); tick(0, 0, '0); tick(0, 0, '0);
        tick(1, 0, '0);
        chk("rd_idle_req", 32'(pr_dram_req), 32'd0);
        tick(0, 0, '0);
        tick(0, 1, 16'hBEEF);
        chk("rd_strobe", 32'(pr_rdstb), 32'h2);
        chk("rd_data", 32'(pr_rddata), 32'hBEEF);
        tick(0, 0, '0);
        chk("rd_strobe_pulse", 32'(pr_rdstb), 32'h0);
        chk("rd_strobe_cnt1", 32'(strb_cnt[1] - snap1), 32'd1);
        chk("rd_strobe_total", 32'(strb_sum - snap_sum), 32'd1);

        // 4: ch3 write then ch2 read
        do_reset();
        ch_addr[3*AW +: AW]   = 21'h00033;
        ch_wrdata[3*DW +: DW] = 16'h00A5;
        ch_bsel[3*2 +: 2]     = 2'b01;
        ch_addr[2*AW +: AW]   = 21'h00022;
        ch_rnw = 4'b0100;
        ch_req = 4'b1000;
        snap2 = strb_cnt[2];
        snap3 = strb_cnt[3];
        snap_sum = strb_sum;
        tick(1, 0, '0);
        chk("wr_grant", 32'(pr_grant), 32'h8);
        chk("wr_rnw", 32'(pr_dram_rnw), 32'd0);
        chk("wr_bsel", 32'(pr_dram_bsel), 32'h1);
        chk("wr_data", 32'(pr_dram_wrdata), 32'h00A5);
        ch_req = 4'b0100;
        tick(0, 0, '0);
        tick(0, 1, 16'h5555);
        chk("wr_empty_rrdy", 32'(pr_rdstb), 32'h0);
        tick(0, 0, '0);
        chk("wr_bsel_stable", 32'(pr_dram_bsel), 32'h1);
        tick(1, 0, '0);
        chk("rd2_grant", 32'(pr_grant), 32'h4);
        chk("rd2_rnw", 32'(pr_dram_rnw), 32'd1);
        ch_req = '0;
        tick(0, 1, 16'h6666);
        chk("wr_exec_rrdy", 32'(pr_rdstb), 32'h0);
        tick(0, 0, '0);
        tick(1, 0, '0);
        tick(0, 1, 16'h1234);
        chk("rd2_strobe", 32'(pr_rdstb), 32'h4);
        chk("rd2_data", 32'(pr_rddata), 32'h1234);
        tick(0, 0, '0);
        chk("rd2_cnt_ch2", 32'(strb_cnt[2] - snap2), 32'd1);
        chk("rd2_cnt_ch3", 32'(strb_cnt[3] - snap3), 32'd0);
        chk("rd2_cnt_total", 32'(strb_sum - snap_sum), 32'd1);

        // 5: idle cycles, rrdy pulses must be ignored
        snap_sum = strb_sum;
        snap_gnt = gnt_sum;
        for (int n = 0; n < 5; n++) begin
            tick(1, 0, '0);
            chk("idle_req", 32'(pr_dram_req), 32'd0);
            tick(0, 1, 16'h7777);
            chk("idle_rdstb", 32'(pr_rdstb), 32'h0);
            tick(0, 0, '0);
        end
        chk("idle_grants", 32'(gnt_sum - snap_gnt), 32'd0);
        chk("idle_strobes", 32'(strb_sum - snap_sum), 32'd0);

        // 6: async reset while a ch1 read sits in the exec slot
        do_reset();
        ch_addr[1*AW +: AW] = 21'h1ABCD;
        ch_rnw = 4'b0010;
        ch_req = 4'b0010;
        tick(1, 0, '0);
        chk("pre_rst_rr_grant", 32'(rr_grant), 32'h2);
        ch_req = '0;
        tick(0, 0, '0);
        tick(1, 0, '0);
        snap_sum = strb_sum;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_addr", 32'(pr_dram_addr), 32'd0);
        chk("arst_rnw_req", 32'({pr_dram_rnw, pr_dram_req, rr_dram_rnw, rr_dram_req}), 32'd0);
        chk("arst_wr_bsel", 32'({pr_dram_wrdata, pr_dram_bsel}), 32'd0);
        chk("arst_grant_strb", 32'({pr_grant, pr_rdstb, rr_grant, rr_rdstb}), 32'd0);
        chk("arst_rddata", 32'(pr_rddata), 32'd0);
        @(posedge fclk);
        #1;
        rst_n = 1'b1;
        tick(0, 1, 16'hBEEF);
        chk("post_rst_rdstb", 32'(pr_rdstb), 32'h0);
        tick(1, 0, '0);
        chk("post_rst_noreq", 32'(pr_dram_req), 32'd0);
        chk("post_rst_strobes", 32'(strb_sum - snap_sum), 32'd0);
        ch_rnw = 4'b1111;
        ch_req = 4'b1111;
        tick(1, 0, '0);
        chk("post_rst_rr_grant", 32'(rr_grant), 32'h1);
        chk("post_rst_pr_grant", 32'(pr_grant), 32'h1);
        ch_req = '0;
        tick(0, 0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
